// File: rtl/rob_commit_pkg.sv
// ============================================================================
// rob_commit_pkg : shared backend definitions for ROB entry layout and
//                  commit-stage FSM encoding (used by ROB, dispatch, commit).
// Revision       : 1.0
// ============================================================================
`default_nettype none

package rob_commit_pkg;

  localparam int unsigned ENTRY_W      = 124;
  localparam int unsigned PC_W         = 64;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned LREG_W       = 5;
  localparam int unsigned PREG_W       = 6;

  localparam int unsigned PC_LSB       = 60;
  localparam int unsigned INSTR_LSB    = 28;
  localparam int unsigned LRS1_LSB     = 23;
  localparam int unsigned LRS2_LSB     = 18;
  localparam int unsigned LRD_LSB      = 13;
  localparam int unsigned PRD_LSB      = 7;
  localparam int unsigned OLD_PRD_LSB  = 1;
  localparam int unsigned RD_VALID_BIT = 0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } commit_state_e;

  // Field order mirrors the bit offsets above, MSB first.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [LREG_W-1:0]  lrs1;
    logic [LREG_W-1:0]  lrs2;
    logic [LREG_W-1:0]  lrd;
    logic [PREG_W-1:0]  prd;
    logic [PREG_W-1:0]  old_prd;
    logic               rd_valid;
  } rob_entry_t;

  // x0 is hardwired, so it never owns a physical register mapping.
  function automatic logic entry_writes_rd(input rob_entry_t e);
    return e.rd_valid && (e.lrd != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob_commit_slot.sv
// ============================================================================
// rob_commit_slot : per-slot commit qualification and registered ARAT /
//                   free-list write port.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module rob_commit_slot
  import rob_commit_pkg::*;
#(
  parameter int DATA_WIDTH = 124,
  parameter int PREG_WIDTH = 6,
  parameter int LREG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_allow,
  input  logic                  i_valid,
  input  logic                  i_complete,
  input  logic                  i_exc,
  input  logic [DATA_WIDTH-1:0] i_entry,
  output logic                  o_commit,
  output logic                  o_arat_we,
  output logic [LREG_WIDTH-1:0] o_arat_lrd,
  output logic [PREG_WIDTH-1:0] o_arat_prd,
  output logic                  o_free_en,
  output logic [PREG_WIDTH-1:0] o_free_preg
);

  rob_entry_t            w_entry;
  logic                  w_commit;
  logic                  w_wr;

  logic                  r_wr;
  logic [LREG_WIDTH-1:0] r_lrd;
  logic [PREG_WIDTH-1:0] r_prd;
  logic [PREG_WIDTH-1:0] r_old_prd;

  assign w_entry  = i_entry;
  assign w_commit = i_allow & i_valid & i_complete & ~i_exc;
  assign w_wr     = w_commit & entry_writes_rd(w_entry);

  // The free list reclaims the previous mapping exactly when the ARAT
  // overwrites it, so both ports share one write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr      <= 1'b0;
      r_lrd     <= '0;
      r_prd     <= '0;
      r_old_prd <= '0;
    end else begin
      r_wr <= w_wr;
      if (w_commit) begin
        r_lrd     <= w_entry.lrd;
        r_prd     <= w_entry.prd;
        r_old_prd <= w_entry.old_prd;
      end
    end
  end

  assign o_commit    = w_commit;
  assign o_arat_we   = r_wr;
  assign o_arat_lrd  = r_lrd;
  assign o_arat_prd  = r_prd;
  assign o_free_en   = r_wr;
  assign o_free_preg = r_old_prd;

endmodule

`default_nettype wire

// File: rtl/rob_commit.sv
// ============================================================================
// rob_commit : two-wide in-order retirement from the ROB head with ARAT and
//              free-list update, exception flush and retirement counters.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DATA_WIDTH = 124,
  parameter int PREG_WIDTH = 6,
  parameter int LREG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_head0_valid,
  input  logic                  i_head1_valid,
  input  logic [DATA_WIDTH-1:0] i_head0_entry,
  input  logic [DATA_WIDTH-1:0] i_head1_entry,
  input  logic                  i_head0_complete,
  input  logic                  i_head1_complete,
  input  logic                  i_head0_exc,
  input  logic                  i_head1_exc,
  input  logic                  i_rob_empty,
  output logic                  o_rd_en1,
  output logic                  o_rd_en2,
  output logic                  o_arat_we0,
  output logic                  o_arat_we1,
  output logic [LREG_WIDTH-1:0] o_arat_lrd0,
  output logic [LREG_WIDTH-1:0] o_arat_lrd1,
  output logic [PREG_WIDTH-1:0] o_arat_prd0,
  output logic [PREG_WIDTH-1:0] o_arat_prd1,
  output logic                  o_free_en0,
  output logic                  o_free_en1,
  output logic [PREG_WIDTH-1:0] o_free_preg0,
  output logic [PREG_WIDTH-1:0] o_free_preg1,
  output logic                  o_flush_valid,
  output logic [63:0]           o_flush_pc,
  output logic [63:0]           o_instret,
  output logic [31:0]           o_exc_count
);

  commit_state_e r_state;
  logic          r_flush_valid;
  logic [63:0]   r_flush_pc;
  logic [63:0]   r_instret;
  logic [31:0]   r_exc_count;

  logic          w_run;
  logic          w_c0;
  logic          w_c1;
  logic          w_flush_req;
  logic [1:0]    w_retire_cnt;
  logic [63:0]   w_head0_pc;

  // Gating with reset_n keeps the dequeue strobes low while reset is held.
  assign w_run        = reset_n & (r_state == ST_RUN);
  assign w_flush_req  = w_run & i_head0_valid & i_head0_complete & i_head0_exc;
  assign w_retire_cnt = {1'b0, w_c0} + {1'b0, w_c1};
  assign w_head0_pc   = i_head0_entry[PC_LSB +: PC_W];

  rob_commit_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .PREG_WIDTH (PREG_WIDTH),
    .LREG_WIDTH (LREG_WIDTH)
  ) u_slot0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_allow     (w_run),
    .i_valid     (i_head0_valid),
    .i_complete  (i_head0_complete),
    .i_exc       (i_head0_exc),
    .i_entry     (i_head0_entry),
    .o_commit    (w_c0),
    .o_arat_we   (o_arat_we0),
    .o_arat_lrd  (o_arat_lrd0),
    .o_arat_prd  (o_arat_prd0),
    .o_free_en   (o_free_en0),
    .o_free_preg (o_free_preg0)
  );

  // Slot 1 may only retire behind slot 0, preserving program order.
  rob_commit_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .PREG_WIDTH (PREG_WIDTH),
    .LREG_WIDTH (LREG_WIDTH)
  ) u_slot1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_allow     (w_c0),
    .i_valid     (i_head1_valid),
    .i_complete  (i_head1_complete),
    .i_exc       (i_head1_exc),
    .i_entry     (i_head1_entry),
    .o_commit    (w_c1),
    .o_arat_we   (o_arat_we1),
    .o_arat_lrd  (o_arat_lrd1),
    .o_arat_prd  (o_arat_prd1),
    .o_free_en   (o_free_en1),
    .o_free_preg (o_free_preg1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_flush_valid <= 1'b0;
      r_flush_pc    <= '0;
      r_instret     <= '0;
      r_exc_count   <= '0;
    end else begin
      r_flush_valid <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_instret <= r_instret + {62'd0, w_retire_cnt};
          if (w_flush_req) begin
            r_flush_valid <= 1'b1;
            r_flush_pc    <= w_head0_pc;
            r_exc_count   <= r_exc_count + 32'd1;
            r_state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_RECOVER;
        end
        // Wait for the ROB to finish discarding wrong-path entries.
        ST_RECOVER: begin
          if (i_rob_empty) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign o_rd_en1      = w_c0;
  assign o_rd_en2      = w_c1;
  assign o_flush_valid = r_flush_valid;
  assign o_flush_pc    = r_flush_pc;
  assign o_instret     = r_instret;
  assign o_exc_count   = r_exc_count;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// ============================================================================
// tb_rob_commit : directed vector table, exception/reset sequences and a
//                 randomized queue-level ROB model for rob_commit.
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rob_commit;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_head0_valid, i_head1_valid;
  logic [123:0] i_head0_entry, i_head1_entry;
  logic         i_head0_complete, i_head1_complete;
  logic         i_head0_exc, i_head1_exc;
  logic         i_rob_empty;
  logic         o_rd_en1, o_rd_en2;
  logic         o_arat_we0, o_arat_we1;
  logic [4:0]   o_arat_lrd0, o_arat_lrd1;
  logic [5:0]   o_arat_prd0, o_arat_prd1;
  logic         o_free_en0, o_free_en1;
  logic [5:0]   o_free_preg0, o_free_preg1;
  logic         o_flush_valid;
  logic [63:0]  o_flush_pc, o_instret;
  logic [31:0]  o_exc_count;

  rob_commit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_head0_valid    (i_head0_valid),
    .i_head1_valid    (i_head1_valid),
    .i_head0_entry    (i_head0_entry),
    .i_head1_entry    (i_head1_entry),
    .i_head0_complete (i_head0_complete),
    .i_head1_complete (i_head1_complete),
    .i_head0_exc      (i_head0_exc),
    .i_head1_exc      (i_head1_exc),
    .i_rob_empty      (i_rob_empty),
    .o_rd_en1         (o_rd_en1),
    .o_rd_en2         (o_rd_en2),
    .o_arat_we0       (o_arat_we0),
    .o_arat_we1       (o_arat_we1),
    .o_arat_lrd0      (o_arat_lrd0),
    .o_arat_lrd1      (o_arat_lrd1),
    .o_arat_prd0      (o_arat_prd0),
    .o_arat_prd1      (o_arat_prd1),
    .o_free_en0       (o_free_en0),
    .o_free_en1       (o_free_en1),
    .o_free_preg0     (o_free_preg0),
    .o_free_preg1     (o_free_preg1),
    .o_flush_valid    (o_flush_valid),
    .o_flush_pc       (o_flush_pc),
    .o_instret        (o_instret),
    .o_exc_count      (o_exc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [123:0] mk(input logic [63:0] pc, input logic [4:0] lrd,
                                      input logic [5:0] prd, input logic [5:0] old, input bit rdv);
    logic [31:0] instr;
    logic [9:0]  lrs;
    instr = $urandom;
    lrs   = 10'($urandom);
    return {pc, instr, lrs, lrd, prd, old, rdv};
  endfunction

  task automatic drive(input bit h0v, input bit h0c, input bit h0x, input logic [123:0] e0,
                       input bit h1v, input bit h1c, input bit h1x, input logic [123:0] e1,
                       input bit empty);
    i_head0_valid = h0v; i_head0_complete = h0c; i_head0_exc = h0x; i_head0_entry = e0;
    i_head1_valid = h1v; i_head1_complete = h1c; i_head1_exc = h1x; i_head1_entry = e1;
    i_rob_empty   = empty;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en1"}, o_rd_en1, 0);
    chk({tag, "_rd_en2"}, o_rd_en2, 0);
    chk({tag, "_arat_we0"}, o_arat_we0, 0);
    chk({tag, "_arat_we1"}, o_arat_we1, 0);
    chk({tag, "_free_en0"}, o_free_en0, 0);
    chk({tag, "_free_en1"}, o_free_en1, 0);
    chk({tag, "_flush_valid"}, o_flush_valid, 0);
    chk({tag, "_flush_pc"}, o_flush_pc, 0);
    chk({tag, "_instret"}, o_instret, 0);
    chk({tag, "_exc_count"}, o_exc_count, 0);
  endtask

  typedef struct {
    bit         h0v, h0c, h1v, h1c;
    logic [4:0] lrd0, lrd1;
    logic [5:0] prd0, prd1, old0, old1;
    bit         rdv0, rdv1;
    bit         x_rd1, x_rd2, x_we0, x_we1;
    int         x_dinst;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  lrd;
    logic [5:0]  prd, old;
    bit          rdv, done, exc;
  } ins_t;

  vec_t        vecs[9];
  vec_t        v;
  ins_t        rob[$];
  ins_t        ni;
  logic [63:0] exp_inst;
  logic [31:0] exp_exc;
  logic [63:0] exp_fpc;
  int          phase, nphase, k;
  bit          exc_head;
  bit          xwe0, xwe1;
  ins_t        r0, r1;
  logic [123:0] e0, e1;

  initial begin
    // {h0v,h0c,h1v,h1c, lrd0,lrd1, prd0,prd1, old0,old1, rdv0,rdv1, rd1,rd2,we0,we1, dinst}
    vecs[0] = '{1,1,1,1,  3, 7, 10,11,  4, 5, 1,1, 1,1,1,1, 2};
    vecs[1] = '{1,1,1,0,  2, 8, 12,13, 14,15, 1,1, 1,0,1,0, 1};
    vecs[2] = '{1,0,1,1,  4, 9, 16,17, 18,19, 1,1, 0,0,0,0, 0};
    vecs[3] = '{1,1,0,1,  0, 6, 20,21, 22,23, 1,1, 1,0,0,0, 1};
    vecs[4] = '{1,1,1,1,  5, 0, 24,25, 26,27, 0,1, 1,1,0,0, 2};
    vecs[5] = '{0,1,1,1,  1, 2, 28,29, 30,31, 1,1, 0,0,0,0, 0};
    vecs[6] = '{1,1,1,1,  9, 9, 32,33, 34,35, 1,1, 1,1,1,1, 2};
    vecs[7] = '{1,1,1,1, 31, 1, 63,62, 61,60, 1,1, 1,1,1,1, 2};
    vecs[8] = '{0,0,0,0,  1, 1,  1, 1,  1, 1, 1,1, 0,0,0,0, 0};

    // Reset with committable heads presented: strobes must stay low.
    reset_n = 1'b0;
    drive(1,1,0, mk(64'h10, 5'd3, 6'd10, 6'd4, 1), 1,1,0, mk(64'h14, 5'd7, 6'd11, 6'd5, 1), 0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset_n  = 1'b1;
    exp_inst = 0;

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      drive(v.h0v, v.h0c, 0, mk(64'h1000 + 64'(i), v.lrd0, v.prd0, v.old0, v.rdv0),
            v.h1v, v.h1c, 0, mk(64'h2000 + 64'(i), v.lrd1, v.prd1, v.old1, v.rdv1), 0);
      #1;
      chk("tbl_rd_en1", o_rd_en1, v.x_rd1);
      chk("tbl_rd_en2", o_rd_en2, v.x_rd2);
      @(posedge clk); #1;
      exp_inst = exp_inst + 64'(v.x_dinst);
      chk("tbl_arat_we0", o_arat_we0, v.x_we0);
      chk("tbl_arat_we1", o_arat_we1, v.x_we1);
      chk("tbl_free_en0", o_free_en0, v.x_we0);
      chk("tbl_free_en1", o_free_en1, v.x_we1);
      chk("tbl_instret", o_instret, exp_inst);
      if (v.x_we0) begin
        chk("tbl_arat_lrd0", o_arat_lrd0, v.lrd0);
        chk("tbl_arat_prd0", o_arat_prd0, v.prd0);
        chk("tbl_free_preg0", o_free_preg0, v.old0);
      end
      if (v.x_we1) begin
        chk("tbl_arat_lrd1", o_arat_lrd1, v.lrd1);
        chk("tbl_arat_prd1", o_arat_prd1, v.prd1);
        chk("tbl_free_preg1", o_free_preg1, v.old1);
      end
    end

    // Exception at head0, flush pulse, recovery gated on rob_empty.
    drive(1,1,1, mk(64'h8000_0040, 5'd1, 6'd2, 6'd3, 1), 1,1,0, mk(64'h44, 5'd2, 6'd4, 6'd5, 1), 0);
    #1;
    chk("exc_rd_en1", o_rd_en1, 0);
    chk("exc_rd_en2", o_rd_en2, 0);
    @(posedge clk); #1;
    chk("exc_flush_valid", o_flush_valid, 1);
    chk("exc_flush_pc", o_flush_pc, 64'h8000_0040);
    chk("exc_count", o_exc_count, 1);
    chk("exc_instret", o_instret, exp_inst);
    chk("exc_arat_we0", o_arat_we0, 0);
    drive(1,1,0, mk(64'h48, 5'd6, 6'd7, 6'd8, 1), 1,1,0, mk(64'h4c, 5'd9, 6'd9, 6'd9, 1), 0);
    #1;
    chk("flush_rd_en1", o_rd_en1, 0);
    @(posedge clk); #1;
    chk("flush_pulse_end", o_flush_valid, 0);
    chk("flush_arat_we0", o_arat_we0, 0);
    chk("flush_instret", o_instret, exp_inst);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("recover_rd_en1", o_rd_en1, 0);
      @(posedge clk); #1;
      chk("recover_instret", o_instret, exp_inst);
      chk("recover_free_en0", o_free_en0, 0);
    end
    i_rob_empty = 1'b1;
    #1;
    chk("recover_empty_rd_en1", o_rd_en1, 0);
    @(posedge clk); #1;
    drive(1,1,0, mk(64'h50, 5'd10, 6'd20, 6'd21, 1), 0,0,0, mk(64'h54, 5'd0, 6'd0, 6'd0, 0), 0);
    #1;
    chk("resume_rd_en1", o_rd_en1, 1);
    chk("resume_rd_en2", o_rd_en2, 0);
    @(posedge clk); #1;
    exp_inst = exp_inst + 1;
    chk("resume_instret", o_instret, exp_inst);
    chk("resume_arat_we0", o_arat_we0, 1);
    chk("resume_arat_lrd0", o_arat_lrd0, 10);

    // head0 retires, head1 excepts; head1 becomes head0 and flushes.
    drive(1,1,0, mk(64'h60, 5'd4, 6'd12, 6'd6, 1), 1,1,1, mk(64'h1234_5678_9abc_def0, 5'd5, 6'd13, 6'd14, 1), 0);
    #1;
    chk("h1exc_rd_en1", o_rd_en1, 1);
    chk("h1exc_rd_en2", o_rd_en2, 0);
    @(posedge clk); #1;
    exp_inst = exp_inst + 1;
    chk("h1exc_instret", o_instret, exp_inst);
    chk("h1exc_arat_we0", o_arat_we0, 1);
    chk("h1exc_arat_we1", o_arat_we1, 0);
    chk("h1exc_free_preg0", o_free_preg0, 6);
    chk("h1exc_no_flush_yet", o_flush_valid, 0);
    drive(1,1,1, mk(64'h1234_5678_9abc_def0, 5'd5, 6'd13, 6'd14, 1), 0,0,0, mk(64'h0, 5'd0, 6'd0, 6'd0, 0), 0);
    #1;
    chk("h1exc_head0_rd_en1", o_rd_en1, 0);
    @(posedge clk); #1;
    chk("h1exc_flush_valid", o_flush_valid, 1);
    chk("h1exc_flush_pc", o_flush_pc, 64'h1234_5678_9abc_def0);
    chk("h1exc_exc_count", o_exc_count, 2);
    drive(1,1,0, mk(64'h70, 5'd3, 6'd3, 6'd3, 1), 0,0,0, mk(64'h0, 5'd0, 6'd0, 6'd0, 0), 0);
    @(posedge clk); #1;
    // Now in RECOVER with rob_empty low: apply asynchronous reset mid-cycle.
    #1;
    chk("rec_pre_reset_rd_en1", o_rd_en1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    reset_n = 1'b1;
    #1;
    chk("post_reset_run_rd_en1", o_rd_en1, 1);
    drive(0,0,0, mk(64'h0, 5'd0, 6'd0, 6'd0, 0), 0,0,0, mk(64'h0, 5'd0, 6'd0, 6'd0, 0), 1);
    @(posedge clk); #1;
    chk("post_reset_instret", o_instret, 0);

    // Randomized traffic against a queue-level ROB model.
    exp_inst = 0; exp_exc = 0; exp_fpc = 0; phase = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (phase == 0 && rob.size() < 6 && $urandom_range(0, 1) == 1) begin
        ni.pc   = {$urandom, $urandom};
        ni.lrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ni.prd  = 6'($urandom);
        ni.old  = 6'($urandom);
        ni.rdv  = ($urandom_range(0, 3) != 0);
        ni.done = 1'b0;
        ni.exc  = ($urandom_range(0, 15) == 0);
        rob.push_back(ni);
      end
      if (phase == 2 && $urandom_range(0, 2) == 0) rob.delete();
      for (int j = 0; j < rob.size() && j < 2; j++)
        if (!rob[j].done && $urandom_range(0, 2) == 0) rob[j].done = 1'b1;

      if (rob.size() > 0) r0 = rob[0]; else begin r0 = ni; r0.done = 1'($urandom); r0.exc = 1'($urandom); end
      if (rob.size() > 1) r1 = rob[1]; else begin r1 = ni; r1.done = 1'($urandom); r1.exc = 1'($urandom); end
      e0 = mk(r0.pc, r0.lrd, r0.prd, r0.old, r0.rdv);
      e1 = mk(r1.pc, r1.lrd, r1.prd, r1.old, r1.rdv);
      drive(rob.size() > 0, r0.done, r0.exc, e0, rob.size() > 1, r1.done, r1.exc, e1, rob.size() == 0);

      k = 0; exc_head = 0;
      if (phase == 0 && rob.size() > 0 && r0.done) begin
        if (r0.exc) exc_head = 1;
        else begin
          k = 1;
          if (rob.size() > 1 && r1.done && !r1.exc) k = 2;
        end
      end
      xwe0 = (k >= 1) && r0.rdv && (r0.lrd != 0);
      xwe1 = (k == 2) && r1.rdv && (r1.lrd != 0);
      exp_inst = exp_inst + 64'(k);
      if (exc_head) begin exp_exc = exp_exc + 1; exp_fpc = r0.pc; end
      if (phase == 0) nphase = exc_head ? 1 : 0;
      else if (phase == 1) nphase = 2;
      else nphase = (rob.size() == 0) ? 0 : 2;

      #1;
      chk("rnd_rd_en1", o_rd_en1, (k >= 1));
      chk("rnd_rd_en2", o_rd_en2, (k == 2));
      for (int j = 0; j < k; j++) void'(rob.pop_front());
      @(posedge clk); #1;
      chk("rnd_arat_we0", o_arat_we0, xwe0);
      chk("rnd_arat_we1", o_arat_we1, xwe1);
      chk("rnd_free_en0", o_free_en0, xwe0);
      chk("rnd_free_en1", o_free_en1, xwe1);
      if (xwe0) begin
        chk("rnd_arat_lrd0", o_arat_lrd0, r0.lrd);
        chk("rnd_arat_prd0", o_arat_prd0, r0.prd);
        chk("rnd_free_preg0", o_free_preg0, r0.old);
      end
      if (xwe1) begin
        chk("rnd_arat_lrd1", o_arat_lrd1, r1.lrd);
        chk("rnd_arat_prd1", o_arat_prd1, r1.prd);
        chk("rnd_free_preg1", o_free_preg1, r1.old);
      end
      chk("rnd_instret", o_instret, exp_inst);
      chk("rnd_exc_count", o_exc_count, exp_exc);
      chk("rnd_flush_valid", o_flush_valid, exc_head);
      if (exc_head) chk("rnd_flush_pc", o_flush_pc, exp_fpc);
      phase = nphase;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
